// File: rtl/lsu_mem_access_if.sv
// Data-RAM bus between the LSU and the RAM.
// Single-outstanding request/response handshake.
interface lsu_mem_access_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_req_wen;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [DATA_W-1:0] bus_req_wdata;
  logic [7:0]        bus_req_wstrb;
  logic              bus_rsp_valid;
  logic [DATA_W-1:0] bus_rsp_rdata;

  modport master (
    output bus_req_valid,
    input  bus_req_ready,
    output bus_req_wen,
    output bus_req_addr,
    output bus_req_wdata,
    output bus_req_wstrb,
    input  bus_rsp_valid,
    input  bus_rsp_rdata
  );

  modport slave (
    input  bus_req_valid,
    output bus_req_ready,
    input  bus_req_wen,
    input  bus_req_addr,
    input  bus_req_wdata,
    input  bus_req_wstrb,
    output bus_rsp_valid,
    output bus_rsp_rdata
  );
endinterface

// File: rtl/lsu_mem_access.sv
// MEM-stage load/store controller: one access in flight,
// store lane alignment, raw load capture for sign-extend.
module lsu_mem_access #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_store_size,
  input  logic [DATA_W-1:0] mem_store_data,
  lsu_mem_access_if.master  bus,
  output logic [DATA_W-1:0] ld_read_data,
  output logic [2:0]        ld_addr_low,
  output logic [2:0]        ld_load_type,
  output logic              lsu_done,
  output logic              lsu_stall,
  output logic              lsu_misalign
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t            state_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wstrb_q;
  logic [2:0]        low_q;
  logic [2:0]        ltype_q;
  logic              done_q;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        ld_low_q;
  logic [2:0]        ld_type_q;

  logic       access;
  logic       accept;
  logic [1:0] acc_sz;
  logic [7:0] st_mask;
  logic [DATA_W-1:0] wdata_d;
  logic [7:0]        wstrb_d;

  assign access = mem_read | mem_write;

  // log2 of access bytes: load type for loads, store size otherwise
  always_comb begin
    acc_sz = mem_store_size;
    if (mem_read) begin
      unique case (mem_load_type)
        3'b010, 3'b110: acc_sz = 2'd1;
        3'b011, 3'b111: acc_sz = 2'd2;
        3'b100:         acc_sz = 2'd3;
        default:        acc_sz = 2'd0;
      endcase
    end
  end

  // base byte-strobe pattern for the store size
  always_comb begin
    st_mask = 8'h01;
    unique case (mem_store_size)
      2'd0: st_mask = 8'h01;
      2'd1: st_mask = 8'h03;
      2'd2: st_mask = 8'h0F;
      2'd3: st_mask = 8'hFF;
      default: st_mask = 8'h01;
    endcase
  end

  assign wdata_d = mem_store_data << {mem_addr[2:0], 3'b000};
  assign wstrb_d = st_mask << mem_addr[2:0];

  assign lsu_misalign = mem_valid & access & (
      ((acc_sz == 2'd1) & mem_addr[0])
    | ((acc_sz == 2'd2) & (|mem_addr[1:0]))
    | ((acc_sz == 2'd3) & (|mem_addr[2:0])));

  assign lsu_stall = mem_valid & access
                   & ~lsu_misalign & ~done_q;
  assign accept    = lsu_stall & (state_q == IDLE);

  // transaction FSM with registered bus and load outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      low_q     <= '0;
      ltype_q   <= '0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      ld_low_q  <= '0;
      ld_type_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= REQ;
            wen_q   <= mem_write;
            addr_q  <= {mem_addr[ADDR_W-1:3], 3'b000};
            wdata_q <= mem_write ? wdata_d : '0;
            wstrb_q <= mem_write ? wstrb_d : 8'h00;
            low_q   <= mem_addr[2:0];
            ltype_q <= mem_load_type;
          end
        end
        REQ: begin
          if (bus.bus_req_ready) state_q <= RESP;
        end
        RESP: begin
          if (bus.bus_rsp_valid) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            if (!wen_q) begin
              rdata_q   <= bus.bus_rsp_rdata;
              ld_low_q  <= low_q;
              ld_type_q <= ltype_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bus_req_valid = (state_q == REQ);
  assign bus.bus_req_wen   = wen_q;
  assign bus.bus_req_addr  = addr_q;
  assign bus.bus_req_wdata = wdata_q;
  assign bus.bus_req_wstrb = wstrb_q;

  assign ld_read_data = rdata_q;
  assign ld_addr_low  = ld_low_q;
  assign ld_load_type = ld_type_q;
  assign lsu_done     = done_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Bench for lsu_mem_access: directed plan cases plus
// randomized accesses against a byte-level reference model.
module tb_lsu_mem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_read, mem_write;
  logic [63:0] mem_addr;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_store_size;
  logic [63:0] mem_store_data;
  logic [63:0] ld_read_data;
  logic [2:0]  ld_addr_low, ld_load_type;
  logic        lsu_done, lsu_stall, lsu_misalign;

  int errors = 0;
  int checks = 0;
  int req_cnt = 0;
  logic [63:0] m_data;
  logic [2:0]  m_low, m_type;

  lsu_mem_access_if bus ();

  lsu_mem_access dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_load_type(mem_load_type),
    .mem_store_size(mem_store_size),
    .mem_store_data(mem_store_data),
    .bus(bus),
    .ld_read_data(ld_read_data),
    .ld_addr_low(ld_addr_low),
    .ld_load_type(ld_load_type),
    .lsu_done(lsu_done), .lsu_stall(lsu_stall),
    .lsu_misalign(lsu_misalign)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && bus.bus_req_valid && bus.bus_req_ready)
      req_cnt++;

  function automatic int ld_bytes(logic [2:0] t);
    case (t)
      3'd1, 3'd5: return 1;
      3'd2, 3'd6: return 2;
      3'd3, 3'd7: return 4;
      3'd4:       return 8;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic run_txn(
    input bit rd, input logic [2:0] lt,
    input logic [1:0] sz, input logic [63:0] a,
    input logic [63:0] sdat, input int rw, input int pw,
    input logic [63:0] rdat, input bit hold,
    input bit drop);
    int n, lo;
    logic [63:0] ea, ew;
    logic [7:0] es;
    lo = int'(a % 8);
    n  = rd ? ld_bytes(lt) : (1 << sz);
    ea = a - 64'(lo);
    ew = '0;
    es = '0;
    if (!rd)
      for (int i = 0; i < 8; i++) begin
        es[i] = (i >= lo) && (i < lo + n);
        if (i >= lo) ew[8*i +: 8] = sdat[8*(i-lo) +: 8];
      end
    mem_valid = 1; mem_read = rd; mem_write = !rd;
    mem_addr = a; mem_load_type = lt;
    mem_store_size = sz; mem_store_data = sdat;
    bus.bus_req_ready = 0; bus.bus_rsp_valid = 0;
    #1;
    checks++;
    if (lsu_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_accept got %b want 1", lsu_stall);
    end
    checks++;
    if (lsu_misalign !== 1'b0) begin
      errors++;
      $display("FAIL misalign_ok got %b want 0", lsu_misalign);
    end
    checks++;
    if (bus.bus_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_req got %b want 0", bus.bus_req_valid);
    end
    @(posedge clk);
    for (int w = 0; w <= rw; w++) begin
      @(negedge clk);
      if (drop) mem_valid = 0;
      #1;
      checks++;
      if (bus.bus_req_valid !== 1'b1 || bus.bus_req_wen !== !rd
          || bus.bus_req_addr !== ea
          || bus.bus_req_wstrb !== es) begin
        errors++;
        $display("FAIL req_fields v=%b wen=%b a=%h s=%h want a=%h s=%h",
          bus.bus_req_valid, bus.bus_req_wen,
          bus.bus_req_addr, bus.bus_req_wstrb, ea, es);
      end
      if (!rd) begin
        checks++;
        if (bus.bus_req_wdata !== ew) begin
          errors++;
          $display("FAIL req_wdata got %h want %h",
            bus.bus_req_wdata, ew);
        end
      end
      checks++;
      if (lsu_stall !== !drop || lsu_done !== 1'b0) begin
        errors++;
        $display("FAIL req_stall stall=%b done=%b want %b/0",
          lsu_stall, lsu_done, !drop);
      end
      bus.bus_req_ready = (w == rw);
      @(posedge clk);
    end
    for (int w = 0; w <= pw; w++) begin
      @(negedge clk);
      bus.bus_req_ready = 0;
      bus.bus_rsp_valid = (w == pw);
      bus.bus_rsp_rdata = (w == pw) ? rdat : r64();
      #1;
      checks++;
      if (bus.bus_req_valid !== 1'b0 || lsu_done !== 1'b0
          || lsu_stall !== !drop) begin
        errors++;
        $display("FAIL resp_wait v=%b done=%b stall=%b",
          bus.bus_req_valid, lsu_done, lsu_stall);
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.bus_rsp_valid = 0;
    bus.bus_rsp_rdata = r64();
    if (rd) begin
      m_data = rdat;
      m_low  = 3'(lo);
      m_type = lt;
    end
    #1;
    checks++;
    if (lsu_done !== 1'b1 || lsu_stall !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle done=%b stall=%b want 1/0",
        lsu_done, lsu_stall);
    end
    checks++;
    if (ld_read_data !== m_data || ld_addr_low !== m_low
        || ld_load_type !== m_type) begin
      errors++;
      $display("FAIL ld_out %h/%0d/%0d want %h/%0d/%0d",
        ld_read_data, ld_addr_low, ld_load_type,
        m_data, m_low, m_type);
    end
    if (!hold) mem_valid = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (lsu_done !== 1'b0 || bus.bus_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_done done=%b v=%b want 0/0",
        lsu_done, bus.bus_req_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1; mem_valid = 0; mem_read = 0; mem_write = 0;
    mem_addr = '0; mem_load_type = '0;
    mem_store_size = '0; mem_store_data = '0;
    bus.bus_req_ready = 0; bus.bus_rsp_valid = 0;
    bus.bus_rsp_rdata = '0;
    m_data = '0; m_low = '0; m_type = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.bus_req_valid !== 0 || bus.bus_req_wen !== 0
        || bus.bus_req_addr !== 0 || bus.bus_req_wdata !== 0
        || bus.bus_req_wstrb !== 0 || ld_read_data !== 0
        || ld_addr_low !== 0 || ld_load_type !== 0
        || lsu_done !== 0 || lsu_stall !== 0) begin
      errors++;
      $display("FAIL reset_state v=%b a=%h d=%h done=%b",
        bus.bus_req_valid, bus.bus_req_addr,
        ld_read_data, lsu_done);
    end
    rst = 0;
  endtask

  task automatic test_aligned_ld();
    @(negedge clk);
    run_txn(1, 3'b100, 2'd0, 64'h8000_0010, '0, 0, 0,
      64'h1122334455667788, 0, 0);
  endtask

  task automatic test_sb();
    @(negedge clk);
    run_txn(0, 3'b000, 2'd0, 64'h8000_0005, 64'hAB, 0, 0,
      '0, 0, 0);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    run_txn(1, 3'b011, 2'd0, 64'h8000_1234, '0, 3, 2,
      r64(), 0, 0);
  endtask

  task automatic test_misaligned();
    int c0;
    @(negedge clk);
    c0 = req_cnt;
    mem_valid = 1; mem_read = 1; mem_write = 0;
    mem_load_type = 3'b010; mem_addr = 64'h8000_0003;
    #1;
    checks++;
    if (lsu_misalign !== 1'b1 || lsu_stall !== 1'b0) begin
      errors++;
      $display("FAIL misalign_lh mis=%b stall=%b want 1/0",
        lsu_misalign, lsu_stall);
    end
    bus.bus_req_ready = 1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bus.bus_req_valid !== 1'b0 || lsu_done !== 1'b0) begin
        errors++;
        $display("FAIL misalign_noreq v=%b done=%b",
          bus.bus_req_valid, lsu_done);
      end
    end
    checks++;
    if (req_cnt != c0) begin
      errors++;
      $display("FAIL misalign_cnt got %0d want %0d",
        req_cnt, c0);
    end
    bus.bus_req_ready = 0;
    mem_valid = 0;
  endtask

  task automatic test_back_to_back();
    int c0;
    @(negedge clk);
    c0 = req_cnt;
    run_txn(1, 3'b101, 2'd0, 64'h8000_0107, '0, 0, 0,
      r64(), 1, 0);
    run_txn(0, 3'b000, 2'd3, 64'h8000_0200,
      64'hDEAD_BEEF_0BAD_F00D, 0, 0, '0, 0, 0);
    checks++;
    if (req_cnt - c0 != 2) begin
      errors++;
      $display("FAIL b2b_count got %0d want 2", req_cnt - c0);
    end
  endtask

  task automatic test_random_access();
    bit rd;
    logic [2:0] lt;
    logic [1:0] sz;
    logic [63:0] a;
    int n;
    @(negedge clk);
    for (int k = 0; k < 24; k++) begin
      rd = 1'($urandom_range(0, 1));
      lt = 3'($urandom_range(1, 7));
      sz = 2'($urandom_range(0, 3));
      n  = rd ? ld_bytes(lt) : (1 << sz);
      a  = r64() & ~64'(n - 1);
      run_txn(rd, lt, sz, a, r64(),
        $urandom_range(0, 3), $urandom_range(0, 3),
        r64(), 1'($urandom_range(0, 1)),
        ($urandom_range(0, 5) == 0));
    end
  endtask

  task automatic test_random_misalign();
    bit rd, em;
    int n;
    @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      rd = 1'($urandom_range(0, 1));
      mem_read = rd; mem_write = !rd;
      mem_load_type = 3'($urandom_range(1, 7));
      mem_store_size = 2'($urandom_range(0, 3));
      mem_addr = r64();
      mem_valid = 1;
      n  = rd ? ld_bytes(mem_load_type) : (1 << mem_store_size);
      em = (mem_addr % 64'(n)) != 0;
      #1;
      checks++;
      if (lsu_misalign !== em || lsu_stall !== !em) begin
        errors++;
        $display("FAIL rand_mis a=%h n=%0d mis=%b stall=%b want %b",
          mem_addr, n, lsu_misalign, lsu_stall, em);
      end
      mem_valid = 0;
      #1;
      checks++;
      if (lsu_misalign !== 1'b0) begin
        errors++;
        $display("FAIL mis_novalid got %b want 0", lsu_misalign);
      end
    end
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    mem_valid = 1; mem_read = 0; mem_write = 1;
    mem_addr = 64'h8000_0040; mem_store_size = 2'd3;
    mem_store_data = r64();
    bus.bus_req_ready = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.bus_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_req got %b want 1", bus.bus_req_valid);
    end
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    m_data = '0; m_low = '0; m_type = '0;
    checks++;
    if (bus.bus_req_valid !== 0 || bus.bus_req_wen !== 0
        || bus.bus_req_addr !== 0 || bus.bus_req_wdata !== 0
        || bus.bus_req_wstrb !== 0 || ld_read_data !== 0
        || ld_addr_low !== 0 || ld_load_type !== 0
        || lsu_done !== 0) begin
      errors++;
      $display("FAIL rst_req_out v=%b a=%h s=%h d=%h done=%b",
        bus.bus_req_valid, bus.bus_req_addr,
        bus.bus_req_wstrb, ld_read_data, lsu_done);
    end
    rst = 0; mem_valid = 0;
    @(negedge clk);
    bus.bus_rsp_valid = 1;
    bus.bus_rsp_rdata = r64();
    @(negedge clk);
    bus.bus_rsp_valid = 0;
    repeat (2) begin
      checks++;
      if (lsu_done !== 1'b0 || bus.bus_req_valid !== 1'b0
          || ld_read_data !== m_data) begin
        errors++;
        $display("FAIL stray_rsp done=%b v=%b d=%h",
          lsu_done, bus.bus_req_valid, ld_read_data);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_aligned_ld();
    test_sb();
    test_backpressure();
    test_misaligned();
    test_back_to_back();
    test_random_access();
    test_random_misalign();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Memory-access controller for the MEM stage of the 64-bit core.
- Takes one load or store per instruction and runs a single-outstanding request/response transaction on the data-RAM bus.
- For stores, aligns the write data and generates byte strobes.
- For loads, registers the raw 64-bit read word plus the address low bits and load type for the downstream ram_signedextend stage.
- Stalls the pipeline until the access completes.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width (fixed 8 bytes; ADDR_LOW is 3 bits).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mem_valid  in  1  MEM stage holds a valid instruction.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store (never both with mem_read).
- mem_addr  in  64  effective byte address.
- mem_load_type  in  3  load encoding: 001 lb, 010 lh, 011 lw, 100 ld, 101 lbu, 110 lhu, 111 lwu.
- mem_store_size  in  2  store size: 00 sb, 01 sh, 10 sw, 11 sd.
- mem_store_data  in  64  store data, right-justified.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  RAM accepts request.
- bus_req_wen  out  1  1 = write.
- bus_req_addr  out  64  8-byte-aligned address, {mem_addr[63:3],3'b0}.
- bus_req_wdata  out  64  lane-aligned write data.
- bus_req_wstrb  out  8  byte strobes (0 for reads).
- bus_rsp_valid  in  1  response valid; rdata valid on reads.
- bus_rsp_rdata  in  64  read word.
- ld_read_data  out  64  registered raw read word, feeds ram_signedextend read_data.
- ld_addr_low  out  3  registered mem_addr[2:0].
- ld_load_type  out  3  registered load type.
- lsu_done  out  1  one-cycle pulse when an access completes.
- lsu_stall  out  1  hold the pipeline.
- lsu_misalign  out  1  combinational misaligned-access flag.

Behaviour:
- FSM states IDLE, REQ, RESP.
  - IDLE → REQ when accept = mem_valid & (mem_read|mem_write) & ~lsu_misalign & ~lsu_done.
  - REQ → RESP when bus_req_ready.
  - RESP → IDLE when bus_rsp_valid.
- On accept, register addr, wen, wdata, wstrb and load_type. The bus outputs are driven from these registers only, so they are stable while bus_req_valid=1.
- bus_req_valid = (state==REQ). Values are held until bus_req_ready. Once asserted, it never drops before the handshake.
- Write alignment:
  - wdata = mem_store_data << (mem_addr[2:0]*8), truncated to 64 bits.
  - wstrb = {01,03,0F,FF}[size] << mem_addr[2:0].
- Misalignment: lsu_misalign = mem_valid & access & ((size 2B & a[0]) | (4B & a[1:0]!=0) | (8B & a[2:0]!=0)).
  - Size comes from the load type for loads and the store size for stores.
  - A misaligned access is never issued on the bus and never stalls.
- Completion: in RESP with bus_rsp_valid, lsu_done=1 in the next cycle for exactly one cycle.
  - Reads capture bus_rsp_rdata into ld_read_data.
  - ld_read_data, ld_addr_low and ld_load_type hold until the next completed load. Stores leave them unchanged.
- lsu_stall = mem_valid & (mem_read|mem_write) & ~lsu_misalign & ~lsu_done.
  - It is combinational and is high in the accept cycle.
  - It drops in the lsu_done cycle so the pipeline advances. No re-issue happens in that cycle because accept is gated by lsu_done.
- Latency: minimum 3 cycles from accept to lsu_done (accept, REQ with ready=1, RESP with rsp_valid=1, done).
  - Each cycle of bus_req_ready=0 or bus_rsp_valid=0 adds one cycle.
- bus_rsp_valid in IDLE or REQ is ignored.
- mem_valid dropping mid-transaction: the transaction completes anyway (no abort). lsu_done still pulses.
- Reset: state=IDLE. All outputs and registers are 0: bus_req_valid, wen, addr, wdata, wstrb, ld_*, lsu_done.
  - Reset mid-REQ drops bus_req_valid the cycle after rst.
  - Reset mid-RESP discards a pending response.

Test Plan:
- Aligned ld: addr=0x8000_0010, type=100, ready=1, rsp 1 cycle later with rdata=0x1122334455667788 → req addr 0x8000_0010, wstrb=0; lsu_done 3 cycles after accept; ld_read_data=0x1122334455667788, ld_addr_low=0.
- sb: addr=0x8000_0005, data=0xAB → wdata=0x0000_AB00_0000_0000, wstrb=0x20, req addr 0x8000_0000, wen=1; ld_* unchanged.
- Backpressure: lw at addr 0x...4 with bus_req_ready low 3 cycles, rsp delayed 2 cycles → req fields stable throughout; lsu_stall high until the done cycle; done at cycle 8; ld_addr_low=4, ld_load_type=011.
- Misaligned: lh at addr 0x...3 → lsu_misalign=1, lsu_stall=0, bus_req_valid never asserts.
- Back-to-back: lbu then sd, mem_valid continuous → exactly two bus requests; no duplicate issue in the done cycle; sd wstrb=0xFF.
- Reset in REQ with ready=0 → bus_req_valid=0 and all outputs 0 next cycle; a stray rsp_valid afterwards produces no lsu_done.
